// File: rtl/y86_mem_arbiter_pkg.sv
// Shared Y86 types: the status code and the memory-arbiter state encoding.
// Pipeline control and the writeback stat logic import these too.
package y86_pkg;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_M = 3'd1,
    BUSY_F = 3'd2,
    DONE_M = 3'd3,
    DONE_F = 3'd4
  } arb_state_t;

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Bundle of the fetch port, the memory-stage port and the unified memory bus.
// master = arbiter view, slave = pipeline/memory view.
interface y86_mem_arbiter_if
  import y86_pkg::*;
#(
  parameter int AW = 64,
  parameter int DW = 64
) ();

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  stat_t         f_stat;
  logic          f_stall;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_done;
  logic [DW-1:0] m_rdata;
  stat_t         m_stat;
  logic          m_stall;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic          mem_err;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  f_req, f_addr, m_req, m_we, m_addr, m_wdata, mem_ack, mem_err, mem_rdata,
    output f_done, f_rdata, f_stat, f_stall, m_done, m_rdata, m_stat, m_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output f_req, f_addr, m_req, m_we, m_addr, m_wdata, mem_ack, mem_err, mem_rdata,
    input  f_done, f_rdata, f_stat, f_stall, m_done, m_rdata, m_stat, m_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/y86_mem_arbiter_pick.sv
// IDLE-cycle winner selection: M has priority unless F has lost STARVE_LIM times in a row.
module y86_arb_pick #(
  parameter int STARVE_LIM = 3
) (
  input  logic       f_req,
  input  logic       m_req,
  input  logic [3:0] starve_cnt,
  output logic       pick_m,
  output logic       pick_f
);

  assign pick_f = f_req & (~m_req | (starve_cnt == 4'(STARVE_LIM)));
  assign pick_m = m_req & ~pick_f;

endmodule

// File: rtl/y86_mem_arbiter.sv
// Single-port memory arbiter between Y86 fetch (read-only) and memory stage.
// Optional abort of stuck transactions: define Y86_ARB_TIMEOUT_EN.
module y86_mem_arbiter
  import y86_pkg::*;
#(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,
  y86_mem_arbiter_if.master  bus
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_starve_lim
    $error("STARVE_LIM must be 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be 2..255");
  end

  arb_state_t    state, state_nxt;
  logic [3:0]    starve_cnt;
  logic          pick_m, pick_f;
  logic          busy, timeout, finish;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;
  logic [DW-1:0] cap_rdata;
  stat_t         cap_stat;

  y86_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .f_req      (bus.f_req),
    .m_req      (bus.m_req),
    .starve_cnt (starve_cnt),
    .pick_m     (pick_m),
    .pick_f     (pick_f)
  );

  assign busy = (state == BUSY_M) || (state == BUSY_F);

`ifdef Y86_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) wait_cnt <= '0;
    else if (busy)            wait_cnt <= wait_cnt + 8'd1;
  end

  // Ack wins a tie with the abort so a real response is never discarded.
  assign timeout = busy && !bus.mem_ack && (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign finish      = busy && (bus.mem_ack || timeout);
  assign grant_addr  = pick_m ? bus.m_addr : bus.f_addr;
  assign grant_wdata = pick_m ? bus.m_wdata : '0;
  assign cap_rdata   = (timeout || bus.mem_we) ? '0 : bus.mem_rdata;
  assign cap_stat    = (timeout || bus.mem_err) ? STAT_ADR : STAT_AOK;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_m) state_nxt = BUSY_M;
               else if (pick_f) state_nxt = BUSY_F;
      BUSY_M:  if (finish) state_nxt = DONE_M;
      BUSY_F:  if (finish) state_nxt = DONE_F;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.f_rdata   <= '0;
      bus.f_stat    <= STAT_AOK;
      bus.m_rdata   <= '0;
      bus.m_stat    <= STAT_AOK;
    end else begin
      state <= state_nxt;

      if (!bus.f_req)                                       starve_cnt <= '0;
      else if (state == IDLE && pick_f)                     starve_cnt <= '0;
      else if (state == IDLE && pick_m &&
               starve_cnt != 4'(STARVE_LIM))                starve_cnt <= starve_cnt + 4'd1;

      if (state == IDLE && (pick_m || pick_f)) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= pick_m & bus.m_we;
        bus.mem_addr  <= grant_addr;
        bus.mem_wdata <= grant_wdata;
      end else if (finish) begin
        bus.mem_req <= 1'b0;
        if (state == BUSY_F) begin
          bus.f_rdata <= cap_rdata;
          bus.f_stat  <= cap_stat;
        end else begin
          bus.m_rdata <= cap_rdata;
          bus.m_stat  <= cap_stat;
        end
      end
    end
  end

  assign bus.f_done  = (state == DONE_F);
  assign bus.m_done  = (state == DONE_M);
  assign bus.f_stall = bus.f_req & ~bus.f_done;
  assign bus.m_stall = bus.m_req & ~bus.m_done;

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Randomized bench for y86_mem_arbiter: a transaction-level model of the requesters,
// the memory and the arbitration rule predicts grants, done pulses, data and status.
module tb_y86_mem_arbiter;
  import y86_pkg::*;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LIM = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  y86_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // memory/transaction model
  bit          busy_t, owner_f, ack_now;
  int          ack_dly, dly_ovr;
  bit          rd_ovr_en;
  logic [63:0] rd_ovr;
  logic [63:0] g_addr, g_wdata;
  logic        g_we;
  bit          exp_f_done, exp_m_done;
  logic [63:0] exp_f_rdata, exp_m_rdata;
  logic [1:0]  exp_f_stat, exp_m_stat;
  int          losses;
  int          m_grants, f_grants, starve_wins;

  task automatic clear_model();
    busy_t = 0; owner_f = 0; ack_now = 0; ack_dly = 0;
    exp_f_done = 0; exp_m_done = 0;
    exp_f_rdata = '0; exp_m_rdata = '0;
    exp_f_stat = 2'd0; exp_m_stat = 2'd0;
    losses = 0;
  endtask

  task automatic new_f();
    bus.f_req  = 1'b1;
    bus.f_addr = {$urandom, $urandom};
  endtask

  task automatic new_m();
    bus.m_req   = 1'b1;
    bus.m_we    = $urandom_range(0, 1);
    bus.m_addr  = {$urandom, $urandom};
    bus.m_wdata = {$urandom, $urandom};
  endtask

  task automatic step();
    bit          f_seen, m_seen, new_grant, pick_f;
    logic [63:0] rd;
    bit          err;
    @(negedge clk);
    check_val("f_done", bus.f_done, exp_f_done);
    check_val("m_done", bus.m_done, exp_m_done);
    check_val("f_rdata", bus.f_rdata, exp_f_rdata);
    check_val("f_stat", bus.f_stat, exp_f_stat);
    check_val("m_rdata", bus.m_rdata, exp_m_rdata);
    check_val("m_stat", bus.m_stat, exp_m_stat);
    check_val("f_stall", bus.f_stall, bus.f_req & ~exp_f_done);
    check_val("m_stall", bus.m_stall, bus.m_req & ~exp_m_done);
    f_seen = exp_f_done;
    m_seen = exp_m_done;
    exp_f_done = 0;
    exp_m_done = 0;

    if (ack_now) begin
      check_val("mem_req_drop", bus.mem_req, 1'b0);
      busy_t  = 0;
      ack_now = 0;
    end
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;

    new_grant = !busy_t && bus.mem_req;
    pick_f    = 0;
    if (new_grant) begin
      // M is older and wins, unless F has already lost LIM grants in a row
      pick_f = bus.f_req && (!bus.m_req || losses == LIM);
      check_val("grant_has_req", bus.mem_req, bus.f_req | bus.m_req);
      check_val("grant_addr", bus.mem_addr, pick_f ? bus.f_addr : bus.m_addr);
      check_val("grant_we", bus.mem_we, pick_f ? 1'b0 : bus.m_we);
      check_val("grant_wdata", bus.mem_wdata, pick_f ? 64'd0 : bus.m_wdata);
      busy_t  = 1;
      owner_f = pick_f;
      g_addr  = pick_f ? bus.f_addr : bus.m_addr;
      g_we    = pick_f ? 1'b0 : bus.m_we;
      g_wdata = pick_f ? 64'd0 : bus.m_wdata;
      ack_dly = (dly_ovr >= 0) ? dly_ovr : $urandom_range(0, 3);
      dly_ovr = -1;
      if (pick_f) f_grants++; else m_grants++;
      if (pick_f && bus.m_req) starve_wins++;
    end else if (busy_t) begin
      check_val("mem_req_hold", bus.mem_req, 1'b1);
      check_val("mem_addr_hold", bus.mem_addr, g_addr);
      check_val("mem_we_hold", bus.mem_we, g_we);
      check_val("mem_wdata_hold", bus.mem_wdata, g_wdata);
    end

    if (!bus.f_req)  losses = 0;
    else if (new_grant) losses = pick_f ? 0 : ((losses < LIM) ? losses + 1 : LIM);

    if (busy_t) begin
      if (ack_dly == 0) begin
        rd  = rd_ovr_en ? rd_ovr : {$urandom, $urandom};
        err = rd_ovr_en ? 1'b0 : ($urandom_range(0, 7) == 0);
        rd_ovr_en     = 0;
        bus.mem_ack   = 1'b1;
        bus.mem_err   = err;
        bus.mem_rdata = rd;
        ack_now       = 1;
        if (owner_f) begin
          exp_f_done  = 1;
          exp_f_rdata = rd;
          exp_f_stat  = err ? 2'd2 : 2'd0;
        end else begin
          exp_m_done  = 1;
          exp_m_rdata = g_we ? 64'd0 : rd;
          exp_m_stat  = err ? 2'd2 : 2'd0;
        end
      end else begin
        ack_dly--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      // stray ack while the arbiter is IDLE or DONE must be ignored
      bus.mem_ack   = 1'b1;
      bus.mem_err   = $urandom_range(0, 1);
      bus.mem_rdata = {$urandom, $urandom};
    end

    if (f_seen) bus.f_req = 1'b0;
    if (m_seen) bus.m_req = 1'b0;
    if (!bus.f_req && $urandom_range(0, 1) == 0) new_f();
    if (!bus.m_req && $urandom_range(0, 3) != 0) new_m();
  endtask

  task automatic reset_mid_busy();
    int budget = 50;
    while (!(busy_t && !ack_now) && budget > 0) begin
      step();
      budget--;
    end
    check_val("reach_busy", busy_t && !ack_now, 1'b1);
    rst         = 1'b1;
    bus.f_req   = 1'b0;
    bus.m_req   = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    @(negedge clk);
    check_val("rst_mem_req", bus.mem_req, 1'b0);
    check_val("rst_f_done", bus.f_done, 1'b0);
    check_val("rst_m_done", bus.m_done, 1'b0);
    check_val("rst_m_rdata", bus.m_rdata, 64'd0);
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    rst           = 1'b1;
    bus.f_req     = 1'b0;
    bus.f_addr    = '0;
    bus.m_req     = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = '0;
    dly_ovr       = -1;
    rd_ovr_en     = 0;
    rd_ovr        = '0;
    m_grants      = 0;
    f_grants      = 0;
    starve_wins   = 0;
    clear_model();
    repeat (2) @(negedge clk);
    check_val("rst_mem_req", bus.mem_req, 1'b0);
    check_val("rst_mem_addr", bus.mem_addr, 64'd0);
    check_val("rst_f_done", bus.f_done, 1'b0);
    check_val("rst_m_done", bus.m_done, 1'b0);
    check_val("rst_f_rdata", bus.f_rdata, 64'd0);
    check_val("rst_m_stat", bus.m_stat, 2'd0);
    rst = 1'b0;

    // first transaction: M read of 0x100, memory answers DEAD three cycles later
    bus.m_req  = 1'b1;
    bus.m_we   = 1'b0;
    bus.m_addr = 64'h100;
    dly_ovr    = 3;
    rd_ovr     = 64'hDEAD;
    rd_ovr_en  = 1;
    repeat (400) step();
    reset_mid_busy();
    repeat (400) step();
    reset_mid_busy();
    repeat (200) step();

    check_val("starve_wins_seen", starve_wins > 0, 1'b1);
    check_val("both_ports_served", (m_grants > 0) && (f_grants > 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
